ex_stage: RTL

- Execute stage. Consumes the ID/EX pipeline register outputs and resolves operand forwarding.
- Performs the 16-bit ALU operation and resolves BEQ branches.
- Registers its results into the EX/MEM pipeline register, which lives inside this block.
- Drives a one-cycle branch redirect to IF and squashes the wrong-path instruction that follows a taken branch.

---
 rtl/ex_stage_if.sv | 51 +++++
 rtl/ex_stage.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/ex_stage_if.sv
// Execute-stage bus: ID/EX operands and control in, MEM/WB bypass in,
// EX/MEM pipeline register and branch redirect out.
interface ex_stage_if #(
    parameter int DW  = 16,
    parameter int PCW = 10,
    parameter int RW  = 4
);
    logic           Stall;
    logic           WBEnable;
    logic           MemReadIn;
    logic           MemWriteIn;
    logic           BrIn;
    logic [2:0]     ALUOp;
    logic [PCW-1:0] PCIn;
    logic [DW-1:0]  Val1;
    logic [DW-1:0]  Val2;
    logic [DW-1:0]  Reg2In;
    logic           ImmSel;
    logic [RW-1:0]  Src1;
    logic [RW-1:0]  Src2;
    logic [RW-1:0]  DstIn;
    logic           MemWbWB;
    logic [RW-1:0]  MemWbDst;
    logic [DW-1:0]  MemWbData;
    logic           WBEnableOut;
    logic           MemReadOut;
    logic           MemWriteOut;
    logic [DW-1:0]  ALUResult;
    logic [DW-1:0]  StoreData;
    logic [RW-1:0]  DstOut;
    logic           BrRedirect;
    logic [PCW-1:0] BrTarget;

    // Upstream pipeline side: drives ID/EX and MEM/WB, observes EX/MEM and redirect
    modport master (
        output Stall, WBEnable, MemReadIn, MemWriteIn, BrIn, ALUOp, PCIn,
               Val1, Val2, Reg2In, ImmSel, Src1, Src2, DstIn,
               MemWbWB, MemWbDst, MemWbData,
        input  WBEnableOut, MemReadOut, MemWriteOut, ALUResult, StoreData,
               DstOut, BrRedirect, BrTarget
    );

    // Execute stage side
    modport slave (
        input  Stall, WBEnable, MemReadIn, MemWriteIn, BrIn, ALUOp, PCIn,
               Val1, Val2, Reg2In, ImmSel, Src1, Src2, DstIn,
               MemWbWB, MemWbDst, MemWbData,
        output WBEnableOut, MemReadOut, MemWriteOut, ALUResult, StoreData,
               DstOut, BrRedirect, BrTarget
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, 16-bit ALU, BEQ resolution, and the
// EX/MEM pipeline register. A taken branch raises a one-cycle redirect and
// turns the next instruction entering EX into a bubble.
module ex_stage #(
    parameter int DW  = 16,
    parameter int PCW = 10,
    parameter int RW  = 4
) (
    input logic       Clk,
    input logic       rst,
    ex_stage_if.slave bus
);

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_e;

    logic           ex_wb_q;
    logic           ex_mem_rd_q;
    logic           ex_mem_wr_q;
    logic [DW-1:0]  ex_alu_q;
    logic [DW-1:0]  ex_store_q;
    logic [RW-1:0]  ex_dst_q;
    logic           redirect_q;
    logic [PCW-1:0] target_q;
    logic           squash_q;

    logic           exmem_fwd_ok;
    logic [DW-1:0]  op_a;
    logic [DW-1:0]  op_b;
    logic [DW-1:0]  cmp_data;
    logic [DW-1:0]  alu_res;
    logic           br_taken;
    logic           kill_ctrl;
    logic [PCW-1:0] br_target;
    alu_op_e        alu_op;

    // Pick the newest producer of a source register; r0 is hardwired and
    // a load sitting in EX/MEM has no data yet, so it is never a source.
    function automatic logic [DW-1:0] fwd_select(
        input logic [RW-1:0] src,
        input logic [DW-1:0] idex_val,
        input logic          exmem_ok,
        input logic [RW-1:0] exmem_dst,
        input logic [DW-1:0] exmem_val,
        input logic          memwb_we,
        input logic [RW-1:0] memwb_dst,
        input logic [DW-1:0] memwb_val
    );
        logic [DW-1:0] sel;
        sel = idex_val;
        if (src != '0) begin
            if (exmem_ok && (exmem_dst == src))
                sel = exmem_val;
            else if (memwb_we && (memwb_dst == src))
                sel = memwb_val;
        end
        return sel;
    endfunction

    // Resolve the three forwarded operands: A, B (register form only) and compare/store data
    always_comb begin
        exmem_fwd_ok = ex_wb_q && !ex_mem_rd_q;
        op_a = fwd_select(bus.Src1, bus.Val1, exmem_fwd_ok, ex_dst_q, ex_alu_q,
                          bus.MemWbWB, bus.MemWbDst, bus.MemWbData);
        if (bus.ImmSel)
            op_b = bus.Val2;
        else
            op_b = fwd_select(bus.Src2, bus.Val2, exmem_fwd_ok, ex_dst_q, ex_alu_q,
                              bus.MemWbWB, bus.MemWbDst, bus.MemWbData);
        cmp_data = fwd_select(bus.Src2, bus.Reg2In, exmem_fwd_ok, ex_dst_q, ex_alu_q,
                              bus.MemWbWB, bus.MemWbDst, bus.MemWbData);
    end

    // ALU on the forwarded operands; shifts only use the low four bits of B
    always_comb begin
        alu_op  = alu_op_e'(bus.ALUOp);
        alu_res = '0;
        case (alu_op)
            ALU_ADD: alu_res = op_a + op_b;
            ALU_SUB: alu_res = op_a - op_b;
            ALU_AND: alu_res = op_a & op_b;
            ALU_OR:  alu_res = op_a | op_b;
            ALU_XOR: alu_res = op_a ^ op_b;
            ALU_SLT: alu_res = {{(DW-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLL: alu_res = op_a << op_b[3:0];
            ALU_SRL: alu_res = op_a >> op_b[3:0];
            default: alu_res = '0;
        endcase
    end

    // BEQ resolution; a squashed instruction or a taken branch must not commit side effects
    always_comb begin
        br_taken  = bus.BrIn && (op_a == cmp_data);
        br_target = bus.PCIn + bus.Val2[PCW-1:0];
        kill_ctrl = squash_q || br_taken;
    end

    // EX/MEM register, redirect pulse and squash flag; reset beats stall, stall freezes everything
    always_ff @(posedge Clk) begin
        if (!rst) begin
            ex_wb_q     <= 1'b0;
            ex_mem_rd_q <= 1'b0;
            ex_mem_wr_q <= 1'b0;
            ex_alu_q    <= '0;
            ex_store_q  <= '0;
            ex_dst_q    <= '0;
            redirect_q  <= 1'b0;
            target_q    <= '0;
            squash_q    <= 1'b0;
        end else if (!bus.Stall) begin
            ex_wb_q     <= bus.WBEnable   && !kill_ctrl;
            ex_mem_rd_q <= bus.MemReadIn  && !kill_ctrl;
            ex_mem_wr_q <= bus.MemWriteIn && !kill_ctrl;
            ex_alu_q    <= alu_res;
            ex_store_q  <= cmp_data;
            ex_dst_q    <= bus.DstIn;
            redirect_q  <= br_taken && !squash_q;
            if (br_taken)
                target_q <= br_target;
            squash_q    <= br_taken && !squash_q;
        end
    end

    assign bus.WBEnableOut = ex_wb_q;
    assign bus.MemReadOut  = ex_mem_rd_q;
    assign bus.MemWriteOut = ex_mem_wr_q;
    assign bus.ALUResult   = ex_alu_q;
    assign bus.StoreData   = ex_store_q;
    assign bus.DstOut      = ex_dst_q;
    assign bus.BrRedirect  = redirect_q;
    assign bus.BrTarget    = target_q;

endmodule
